// File: rtl/div32_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
// Results are registered and held until the next accepted operation completes.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, stateNext;
  logic [WIDTH-1:0]  remReg;
  logic [WIDTH-1:0]  quoReg;
  logic [WIDTH-1:0]  divReg;
  logic [CntW-1:0]   cnt;

  logic [WIDTH:0]    trial;
  logic              trialGe;
  logic [WIDTH-1:0]  remNext;
  logic [WIDTH-1:0]  quoNext;
  logic              lastIter;
  logic              accept;

  assign accept   = (state == IDLE) && start;
  assign lastIter = (state == CALC) && (cnt == CntW'(WIDTH - 1));

  // The remainder register only needs WIDTH bits: it always ends an iteration below the divisor.
  assign trial   = {remReg, quoReg[WIDTH-1]};
  assign trialGe = trial >= {1'b0, divReg};
  assign remNext = trialGe ? (trial[WIDTH-1:0] - divReg) : trial[WIDTH-1:0];
  assign quoNext = {quoReg[WIDTH-2:0], trialGe};

  // NOTE: every clocked block uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // NOTE: stateNext gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = (divisor == '0) ? DONE : CALC;
      CALC:    if (lastIter) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      CALC:    busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      remReg      <= '0;
      quoReg      <= '0;
      divReg      <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      remReg <= '0;
      quoReg <= dividend;
      divReg <= divisor;
      cnt    <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      remReg <= remNext;
      quoReg <= quoNext;
      cnt    <= cnt + CntW'(1);
      if (lastIter) begin
        quotient    <= quoNext;
        remainder   <= remNext;
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div32_seq.sv
// Directed bench for div32_seq: hand-computed quotients, latency, handshake and reset abort.
module tb_div32_seq;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int errors = 0;
  int checks = 0;

  div32_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for done (bounded) and returns the number of edges since the start edge.
  task automatic wait_done(output int cycles);
    cycles = 1;
    while (done !== 1'b1 && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expQ, input logic [31:0] expR,
                        input logic expDbz, input int expLat);
    int cycles;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
    check({tag, " busy after start"}, 32'(busy), 32'd1);
    wait_done(cycles);
    check({tag, " latency"}, 32'(cycles), 32'(expLat));
    check({tag, " quotient"}, quotient, expQ);
    check({tag, " remainder"}, remainder, expR);
    check({tag, " dbz"}, 32'(div_by_zero), 32'(expDbz));
    tick();
    check({tag, " done falls"}, 32'(done), 32'd0);
    check({tag, " busy falls"}, 32'(busy), 32'd0);
    check({tag, " quotient held"}, quotient, expQ);
  endtask

  initial begin
    int cycles;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // 1: reset then idle
    tick();
    tick();
    rst = 1'b0;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst quotient", quotient, 32'd0);
    check("rst remainder", remainder, 32'd0);
    check("rst dbz", 32'(div_by_zero), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle no done", 32'(done), 32'd0);
    end

    // 2-4: basic divisions, boundaries, divide by zero
    run_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, WIDTH + 1);
    run_op("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, WIDTH + 1);
    run_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, WIDTH + 1);
    run_op("3/10", 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, WIDTH + 1);
    run_op("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, WIDTH + 1);
    run_op("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    run_op("9/3", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, WIDTH + 1);

    // 5: start held high and operands changed during CALC
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd33;
    tick();
    cycles = 1;
    while (done !== 1'b1 && cycles < 60) begin
      dividend = dividend + 32'd17;
      divisor  = 32'd0;
      tick();
      cycles++;
    end
    start = 1'b0;
    check("hold latency", 32'(cycles), 32'(WIDTH + 1));
    check("hold quotient", quotient, 32'd30);
    check("hold remainder", remainder, 32'd10);
    check("hold dbz", 32'(div_by_zero), 32'd0);
    tick();
    tick();
    check("hold no second op", 32'(busy), 32'd0);
    check("hold idle quotient", quotient, 32'd30);

    // 6: reset aborts 100/7 mid-flight; rst wins over start
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    tick();
    start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    check("calc keeps prev quotient", quotient, 32'd30);
    check("calc keeps prev remainder", remainder, 32'd10);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", quotient, 32'd0);
    check("abort remainder", remainder, 32'd0);
    for (int i = 0; i < WIDTH + 4; i++) begin
      tick();
      if (done === 1'b1) check("abort no done", 32'(done), 32'd0);
    end
    check("abort stays idle", 32'(busy), 32'd0);
    run_op("50/8", 32'd50, 32'd8, 32'd6, 32'd2, 1'b0, WIDTH + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
